// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package display_pkg;

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Scan controller bus: master supplies digits/enables/tick, slave returns anode and nibble drive.
interface display_scan_ctrl_if;
  import display_pkg::*;

  logic                          tick;
  logic [4*NUM_DIGITS-1:0]       digits;
  logic [NUM_DIGITS-1:0]         digit_en;
  logic                          blank_lz;
  logic [NUM_DIGITS-1:0]         an;
  logic [3:0]                    hex_out;
  logic [$clog2(NUM_DIGITS)-1:0] digit_sel;
  logic                          frame_done;

  modport master (
    output tick, digits, digit_en, blank_lz,
    input  an, hex_out, digit_sel, frame_done
  );

  modport slave (
    input  tick, digits, digit_en, blank_lz,
    output an, hex_out, digit_sel, frame_done
  );

endinterface

// File: rtl/lz_mask.sv
// Leading-zero blanking mask: digit i is blanked when nibbles i..top are all zero.
module lz_mask
  import display_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] snapshot,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   lz_blank
);

  always_comb begin
    logic all_zero;
    lz_blank = '0;
    all_zero = blank_lz;
    // Walk down from the most significant digit; digit 0 is never blanked.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero && (snapshot[4*i +: 4] == 4'h0);
      lz_blank[i] = all_zero;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scanner with guard blanking, per-frame
// snapshot, leading-zero suppression and per-digit enables.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned GUARD_TICKS = 1
) (
  input logic                clock,
  input logic                reset,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned MaxTicks = (ON_TICKS > GUARD_TICKS) ? ON_TICKS : GUARD_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned SelW     = $clog2(NUM_DIGITS);
  localparam logic [CntW-1:0] OnLast    = CntW'(ON_TICKS - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_TICKS - 1);

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [SelW-1:0]         sel_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [3:0]              hex_q;
  logic                    frame_done_q;
  logic [4*NUM_DIGITS-1:0] snap_q;

  logic                    snap_now;
  logic [4*NUM_DIGITS-1:0] snap_eff;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    visible;

  // With a one-tick guard the snapshot and the first digit's reveal share a tick,
  // so the reveal must see the freshly captured value rather than the old register.
  assign snap_now = (state_q == StBlank) && (sel_q == '0) && (cnt_q == '0);
  assign snap_eff = snap_now ? bus.digits : snap_q;

  lz_mask u_lz_mask (
    .snapshot (snap_eff),
    .blank_lz (bus.blank_lz),
    .lz_blank (lz_blank)
  );

  assign visible = bus.digit_en[sel_q] & ~lz_blank[sel_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StBlank;
      cnt_q        <= '0;
      sel_q        <= '0;
      an_q         <= ANODES_OFF;
      hex_q        <= 4'h0;
      frame_done_q <= 1'b0;
      snap_q       <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.tick) begin
        unique case (state_q)
          StBlank: begin
            an_q <= ANODES_OFF;
            if (snap_now) begin
              snap_q <= bus.digits;
            end
            if (cnt_q == GuardLast) begin
              state_q <= StShow;
              cnt_q   <= '0;
              hex_q   <= snap_eff[4*sel_q +: 4];
              an_q    <= visible ? ~(NUM_DIGITS'(1) << sel_q) : ANODES_OFF;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StShow: begin
            if (cnt_q == OnLast) begin
              state_q <= StBlank;
              cnt_q   <= '0;
              an_q    <= ANODES_OFF;
              sel_q   <= sel_q + 1'b1;
              if (sel_q == SelW'(NUM_DIGITS - 1)) begin
                frame_done_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= StBlank;
        endcase
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.hex_out    = hex_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised bench for display_scan_ctrl against a tick-count reference model.
module tb_display_scan_ctrl;

  localparam int unsigned On    = 2;
  localparam int unsigned Guard = 1;
  localparam int unsigned Slot  = On + Guard;
  localparam int unsigned Frame = 4 * Slot;

  logic clock = 1'b0;
  logic reset = 1'b1;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(
    .ON_TICKS    (On),
    .GUARD_TICKS (Guard)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: everything follows from the number of ticks seen since reset.
  int unsigned n;
  logic [15:0] m_snap;
  logic [3:0]  m_hex;
  logic        m_fd;
  logic        m_vis;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_snap = '0; m_hex = '0; m_fd = 1'b0; m_vis = 1'b0;
  endtask

  task automatic model_tick(input logic tk, input logic [15:0] dg, input logic [3:0] en,
                            input logic lz);
    int unsigned q, d, r;
    m_fd = 1'b0;
    if (tk) begin
      if (n % Frame == 0) m_snap = dg;
      n++;
      q = n % Frame;
      d = q / Slot;
      r = q % Slot;
      if (r == Guard) begin
        m_hex = m_snap[4*d +: 4];
        m_vis = en[d] && !(lz && d != 0 && ((m_snap >> (4*d)) == 16'h0));
      end
      if (q == 0) m_fd = 1'b1;
    end
  endtask

  function automatic logic model_showing(input int unsigned dig);
    int unsigned q;
    q = n % Frame;
    return ((q % Slot) >= Guard) && ((q / Slot) == dig);
  endfunction

  task automatic compare_all();
    int unsigned q, d;
    logic [3:0] exp_an;
    q = n % Frame;
    d = q / Slot;
    exp_an = ((q % Slot) >= Guard && m_vis) ? ~(4'b0001 << d) : 4'b1111;
    check_eq("an", 16'(bus.an), 16'(exp_an));
    check_eq("hex_out", 16'(bus.hex_out), 16'(m_hex));
    check_eq("digit_sel", 16'(bus.digit_sel), 16'(d));
    check_eq("frame_done", 16'(bus.frame_done), 16'(m_fd));
  endtask

  task automatic run_cycle(input logic tk);
    bus.tick = tk;
    @(posedge clock);
    model_tick(tk, bus.digits, bus.digit_en, bus.blank_lz);
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic run_fixed(input int cycles, input logic [15:0] dg, input logic [3:0] en,
                           input logic lz);
    bus.digits = dg; bus.digit_en = en; bus.blank_lz = lz;
    for (int c = 0; c < cycles; c++) run_cycle(1'b1);
  endtask

  initial begin
    bool_init();
  end

  task automatic bool_init();
    bit done;
    bus.tick = 1'b0; bus.digits = 16'h1234; bus.digit_en = 4'hF; bus.blank_lz = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    compare_all();
    reset = 1'b0;

    // Plain scan, 1234
    run_fixed(2 * Frame, 16'h1234, 4'hF, 1'b0);

    // Digits change while digit1 is showing; this frame keeps 2,1
    for (int c = 0; c < 2 * Frame; c++) begin
      if (n % Frame == 4) bus.digits = 16'hABCD;
      run_cycle(1'b1);
    end

    run_fixed(Frame, 16'h0040, 4'hF, 1'b1);
    run_fixed(Frame, 16'h0000, 4'hF, 1'b1);
    run_fixed(2 * Frame, 16'h5678, 4'b0101, 1'b0);

    // Sparse tick: every fifth clock
    bus.digits = 16'h9E3F; bus.digit_en = 4'hF; bus.blank_lz = 1'b0;
    for (int c = 0; c < 5 * Frame; c++) run_cycle(c % 5 == 4);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.digits = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) bus.digit_en = 4'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blank_lz = 1'($urandom);
      run_cycle($urandom_range(0, 2) != 0);
    end

    // Async reset during digit2 SHOW
    bus.digits = 16'h4321; bus.digit_en = 4'hF; bus.blank_lz = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 4 * Frame && !done; c++) begin
      run_cycle(1'b1);
      if (model_showing(2)) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL reach_digit2: got no SHOW of digit2 expected one within budget");
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_eq("async_an", 16'(bus.an), 16'h000F);
    check_eq("async_sel", 16'(bus.digit_sel), 16'h0000);
    check_eq("async_hex", 16'(bus.hex_out), 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    run_cycle(1'b1);
    check_eq("first_anode", 16'(bus.an), 16'h000E);
    for (int c = 0; c < Frame; c++) run_cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

endmodule
